module_display_scan_ctrl: RTL and testbench

Controller that time-multiplexes four 4-bit nibbles onto a common-anode 4-digit 7-segment display. It owns a double-buffered digit store, a refresh prescaler and a digit-scan FSM with anti-ghosting guard time. It drives the digit number into module_deco and the active-low anode lines to the board. Runs in the 10 MHz clk_wiz_0 domain.

---
 rtl/display_scan_pkg.sv | 26 ++
 rtl/module_scan_prescaler.sv | 29 ++
 rtl/module_display_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_module_display_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// Shared types and helpers for the 4-digit 7-segment scan controller.
package display_scan_pkg;

    localparam int N_DIGITS = 4;

    typedef logic [3:0] nibble_t;
    typedef logic [1:0] digit_idx_t;

    typedef enum logic {GUARD_S, DRIVE_S} scan_state_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Bit k set when digit k and every digit above it are zero; digit 0 is never set.
    function automatic logic [3:0] lz_blank_mask(input logic [15:0] digits);
        logic [3:0] mask;
        logic       zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (digits[4*k +: 4] == 4'd0);
            mask[k]    = zero_above;
        end
        return mask;
    endfunction

endpackage

// File: rtl/module_scan_prescaler.sv
// Free-running slot prescaler: counts 0..DIV_COUNT-1 and flags the last cycle of each slot.
module module_scan_prescaler #(
    parameter int DIV_COUNT = 10000,
    parameter int CNT_W     = $clog2(DIV_COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             slot_end_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        slot_end_o = (cnt_q == CNT_W'(DIV_COUNT - 1));
        cnt_d      = slot_end_o ? '0 : cnt_q + CNT_W'(1);
        cnt_nxt_o  = cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/module_display_scan_ctrl.sv
// Digit-scan controller: double-buffered digit store, guard-time FSM and registered anode/nibble outputs.
//   state   | meaning
//   GUARD_S | start of slot, all anodes off to avoid ghosting
//   DRIVE_S | selected anode driven (unless leading-zero blanked)
module module_display_scan_ctrl
    import display_scan_pkg::*;
#(
    parameter int DIV_COUNT = 10000,
    parameter int GUARD     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    input  logic       blz_i,
    output logic [3:0] an_o,
    output logic [3:0] num_o,
    output logic       busy_o,
    output logic       commit_done,
    output logic       frame_o
);

    localparam int CNT_W = $clog2(DIV_COUNT);
    localparam scan_state_t RST_STATE  = (GUARD > 0) ? GUARD_S : DRIVE_S;
    localparam scan_state_t SLOT_START = (GUARD > 0) ? GUARD_S : DRIVE_S;

    logic [CNT_W-1:0] cnt_nxt;
    logic             slot_end;

    scan_state_t state_q, state_d;
    digit_idx_t  idx_q, idx_d;
    logic [15:0] staging_q, staging_d;
    logic [15:0] active_q, active_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    nibble_t     num_q, num_d;
    logic        cd_q, cd_d;
    logic        frame_q, frame_d;

    logic        boundary;
    logic        do_copy;
    logic [3:0]  blank_mask;
    logic        blank;

    module_scan_prescaler #(
        .DIV_COUNT (DIV_COUNT),
        .CNT_W     (CNT_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_nxt_o  (cnt_nxt),
        .slot_end_o (slot_end)
    );

    // Outputs are computed from next-state cnt/idx/active so they line up with the held state.
    always_comb begin
        idx_d    = slot_end ? idx_q + digit_idx_t'(1) : idx_q;
        boundary = slot_end && (idx_q == digit_idx_t'(N_DIGITS - 1));

        staging_d = staging_q;
        if (wr_en) begin
            staging_d[{wr_addr, 2'b00} +: 4] = wr_data;
        end

        do_copy   = boundary && (pending_q || commit);
        active_d  = do_copy ? staging_d : active_q;
        pending_d = do_copy ? 1'b0 : (pending_q || commit);
        cd_d      = do_copy;
        frame_d   = boundary;

        state_d = state_q;
        case (state_q)
            GUARD_S: if (cnt_nxt == CNT_W'(GUARD)) state_d = DRIVE_S;
            DRIVE_S: if (slot_end)                 state_d = SLOT_START;
            default: state_d = RST_STATE;
        endcase

        blank_mask = lz_blank_mask(active_d);
        blank      = blz_i && blank_mask[idx_d];

        an_d = AN_OFF;
        if (state_d == DRIVE_S && !blank) begin
            an_d = ~(4'b0001 << idx_d);
        end
        num_d = active_d[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            idx_q     <= '0;
            staging_q <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= AN_OFF;
            num_q     <= '0;
            cd_q      <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            num_q     <= num_d;
            cd_q      <= cd_d;
            frame_q   <= frame_d;
        end
    end

    assign an_o        = an_q;
    assign num_o       = num_q;
    assign busy_o      = pending_q;
    assign commit_done = cd_q;
    assign frame_o     = frame_q;

endmodule

// File: tb/tb_module_display_scan_ctrl.sv
// Bench for module_display_scan_ctrl: time-indexed reference model plus directed and random stimulus.
module tb_module_display_scan_ctrl;

    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic       blz_i;
    logic [3:0] an_o;
    logic [3:0] num_o;
    logic       busy_o;
    logic       commit_done;
    logic       frame_o;

    always #5 clk = ~clk;

    module_display_scan_ctrl #(
        .DIV_COUNT (DIV),
        .GUARD     (GRD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .blz_i       (blz_i),
        .an_o        (an_o),
        .num_o       (num_o),
        .busy_o      (busy_o),
        .commit_done (commit_done),
        .frame_o     (frame_o)
    );

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Model: t is cycles since reset release; cnt = t % DIV, digit = (t / DIV) % 4.
    int         t;
    logic [3:0] stg [4];
    logic [3:0] act [4];
    bit         pend;
    logic [3:0] e_an, e_num;
    logic       e_busy, e_cd, e_fr;

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, got, want);
        end
    endtask

    task automatic model_outputs(input bit blz);
        int cnt, idx;
        bit blank;
        cnt   = t % DIV;
        idx   = (t / DIV) % 4;
        blank = 1'b0;
        if (blz && idx >= 1) begin
            blank = 1'b1;
            for (int j = idx; j < 4; j++) if (act[j] != 4'd0) blank = 1'b0;
        end
        e_an  = (cnt < GRD || blank) ? 4'hF : (4'hF ^ (4'b0001 << idx));
        e_num = act[idx];
    endtask

    task automatic model_reset();
        t = 0;
        for (int j = 0; j < 4; j++) begin
            stg[j] = 4'd0;
            act[j] = 4'd0;
        end
        pend   = 1'b0;
        e_an   = 4'hF;
        e_num  = 4'd0;
        e_busy = 1'b0;
        e_cd   = 1'b0;
        e_fr   = 1'b0;
    endtask

    task automatic model_step();
        bit boundary;
        boundary = (t % FRAME) == FRAME - 1;
        if (wr_en) stg[wr_addr] = wr_data;
        e_cd = 1'b0;
        if (boundary && (pend || commit)) begin
            for (int j = 0; j < 4; j++) act[j] = stg[j];
            pend = 1'b0;
            e_cd = 1'b1;
        end else if (commit) begin
            pend = 1'b1;
        end
        t++;
        e_fr   = boundary;
        e_busy = pend;
        model_outputs(blz_i);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an_o", an_o, e_an);
            chk("num_o", num_o, e_num);
            chk("busy_o", {3'b0, busy_o}, {3'b0, e_busy});
            chk("commit_done", {3'b0, commit_done}, {3'b0, e_cd});
            chk("frame_o", {3'b0, frame_o}, {3'b0, e_fr});
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) tick();
    endtask

    task automatic write_nib(input logic [1:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int cd_cnt;
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 4'd0;
        commit  = 1'b0;
        blz_i   = 1'b0;
        #1 rst_n = 1'b0;
        #1 model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: guard, drive pattern and frame pulse.
        tick(); tick();
        chk("pin_an_t2", an_o, 4'b1110);
        repeat (8) tick();
        chk("pin_an_t10", an_o, 4'b1101);
        wait_phase(0);
        chk("pin_frame_t32", {3'b0, frame_o}, 4'd1);
        repeat (38) tick();

        // Load 1,2,3,4 and commit mid-frame.
        for (int a = 0; a < 4; a++) write_nib(2'(a), 4'(a + 1));
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("pin_busy_pending", {3'b0, busy_o}, 4'd1);
        wait_phase(0);
        chk("pin_commit_done", {3'b0, commit_done}, 4'd1);
        wait_phase(2);
        chk("pin_slot0_num", num_o, 4'd1);
        chk("pin_slot0_an", an_o, 4'b1110);
        wait_phase(26);
        chk("pin_slot3_num", num_o, 4'd4);
        chk("pin_slot3_an", an_o, 4'b0111);

        // Writes without commit leave the active buffer alone.
        for (int i = 0; i < 3 * FRAME; i++) begin
            wr_en   = ($urandom % 2) == 0;
            wr_addr = 2'($urandom % 4);
            wr_data = 4'($urandom % 16);
            tick();
        end
        wr_en = 1'b0;
        wait_phase(10);
        chk("pin_nocommit_slot1", num_o, 4'd2);

        // Leading-zero blanking with digits {0,0,7,0}.
        write_nib(2'd0, 4'd0);
        write_nib(2'd1, 4'd7);
        write_nib(2'd2, 4'd0);
        write_nib(2'd3, 4'd0);
        commit = 1'b1;
        blz_i  = 1'b1;
        tick();
        commit = 1'b0;
        wait_phase(0);
        wait_phase(2);
        chk("pin_blz_d0_an", an_o, 4'b1110);
        wait_phase(10);
        chk("pin_blz_d1_an", an_o, 4'b1101);
        chk("pin_blz_d1_num", num_o, 4'd7);
        wait_phase(18);
        chk("pin_blz_d2_an", an_o, 4'hF);
        wait_phase(26);
        chk("pin_blz_d3_an", an_o, 4'hF);

        // Write plus commit on the boundary cycle itself.
        wait_phase(31);
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 4'd9;
        commit  = 1'b1;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
        chk("pin_bnd_commit_done", {3'b0, commit_done}, 4'd1);
        wait_phase(18);
        chk("pin_bnd_d2_an", an_o, 4'b1011);
        wait_phase(26);
        chk("pin_bnd_d3_num", num_o, 4'd9);
        chk("pin_bnd_d3_an", an_o, 4'b0111);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom % 3) == 0;
            wr_addr = 2'($urandom % 4);
            wr_data = (($urandom % 2) == 0) ? 4'd0 : 4'($urandom % 16);
            commit  = ($urandom % 40) == 0;
            blz_i   = ($urandom % 4) != 0;
            tick();
        end
        wr_en  = 1'b0;
        commit = 1'b0;
        blz_i  = 1'b0;

        // Reset while digit 2 is driven and a commit is pending.
        write_nib(2'd2, 4'd5);
        wait_phase(19);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("pin_rst_busy_before", {3'b0, busy_o}, 4'd1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("pin_rst_an", an_o, 4'hF);
        chk("pin_rst_busy", {3'b0, busy_o}, 4'd0);
        tick(); tick();
        #2 rst_n = 1'b1;
        cd_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (commit_done) cd_cnt++;
        end
        chk("pin_no_cd_after_rst", 4'(cd_cnt), 4'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
